// File: rtl/tc_serial_decode.sv
// Serial two's-complement decoder: collects a WIDTH-bit LSB-first frame and negates it on the fly.
// Optional overflow flag (o_ovf) is built when TC_OVF_FLAG_EN is defined.

module tc_serial_decode #(
   parameter int WIDTH = 8
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic             i,
   input  logic             i_vld,
   input  logic             sof,
   output logic             i_rdy,
   output logic [WIDTH-1:0] o_word,
   output logic [WIDTH-1:0] o_raw,
   output logic             o_vld,
   input  logic             o_rdy,
   output logic             frame_err
`ifdef TC_OVF_FLAG_EN
   ,
   output logic             o_ovf
`endif
);

   // state | meaning
   // IDLE  | waiting for a sof bit; non-sof bits are dropped
   // SHIFT | collecting frame bits, cnt_q is the index of the next bit
   // HOLD  | word presented on o_vld, waiting for o_rdy
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
`ifdef TC_OVF_FLAG_EN
   localparam logic [WIDTH-1:0] OVF_PAT = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   state_t           state_q;
   logic             rdy_q;
   logic             seen_q;
   logic             vld_q;
   logic             ferr_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] raw_sr_q;
   logic [WIDTH-1:0] word_sr_q;
   logic [WIDTH-1:0] raw_q;
   logic [WIDTH-1:0] word_q;
`ifdef TC_OVF_FLAG_EN
   logic             ovf_q;
`endif

   logic             accept;
   logic [CW-1:0]    idx_d;
   logic             seen_d;
   logic             tbit_d;
   logic             last_d;
   logic [WIDTH-1:0] raw_d;
   logic [WIDTH-1:0] word_d;

   // A sof bit always lands at index 0 with seen_one cleared, so the
   // same next-value path serves a fresh start and a mid-frame restart.
   always_comb begin
      accept        = i_vld & rdy_q;
      idx_d         = sof ? '0 : cnt_q;
      seen_d        = sof ? 1'b0 : seen_q;
      tbit_d        = seen_d ? ~i : i;
      last_d        = ~sof & (cnt_q == LAST_IDX);
      raw_d         = sof ? '0 : raw_sr_q;
      word_d        = sof ? '0 : word_sr_q;
      raw_d[idx_d]  = i;
      word_d[idx_d] = tbit_d;
   end

   always_ff @(posedge t_clk) begin
      if (!r) begin
         state_q   <= IDLE;
         rdy_q     <= 1'b1;
         seen_q    <= 1'b0;
         vld_q     <= 1'b0;
         ferr_q    <= 1'b0;
         cnt_q     <= '0;
         raw_sr_q  <= '0;
         word_sr_q <= '0;
         raw_q     <= '0;
         word_q    <= '0;
`ifdef TC_OVF_FLAG_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         ferr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept && sof) begin
                  state_q   <= SHIFT;
                  seen_q    <= i;
                  cnt_q     <= CW'(1);
                  raw_sr_q  <= raw_d;
                  word_sr_q <= word_d;
               end
            end
            SHIFT: begin
               if (accept) begin
                  if (sof)
                     ferr_q <= 1'b1;
                  seen_q <= seen_d | i;
                  if (last_d) begin
                     state_q <= HOLD;
                     rdy_q   <= 1'b0;
                     vld_q   <= 1'b1;
                     cnt_q   <= '0;
                     raw_q   <= raw_d;
                     word_q  <= word_d;
`ifdef TC_OVF_FLAG_EN
                     ovf_q   <= (raw_d == OVF_PAT);
`endif
                  end else begin
                     cnt_q     <= idx_d + 1'b1;
                     raw_sr_q  <= raw_d;
                     word_sr_q <= word_d;
                  end
               end
            end
            HOLD: begin
               if (o_rdy) begin
                  state_q <= IDLE;
                  rdy_q   <= 1'b1;
                  vld_q   <= 1'b0;
`ifdef TC_OVF_FLAG_EN
                  ovf_q   <= 1'b0;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   assign i_rdy     = rdy_q;
   assign o_vld     = vld_q;
   assign o_raw     = raw_q;
   assign o_word    = word_q;
   assign frame_err = ferr_q;
`ifdef TC_OVF_FLAG_EN
   assign o_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_tc_serial_decode.sv
// Bench for tc_serial_decode (WIDTH=8): directed scenarios plus randomized frames
// checked against an arithmetic negation model. Build with TC_OVF_FLAG_EN to cover o_ovf.

module tb_tc_serial_decode;

   localparam int W = 8;

   logic         t_clk = 1'b0;
   logic         r     = 1'b0;
   logic         i     = 1'b0;
   logic         i_vld = 1'b0;
   logic         sof   = 1'b0;
   logic         o_rdy = 1'b1;
   logic         i_rdy;
   logic [W-1:0] o_word;
   logic [W-1:0] o_raw;
   logic         o_vld;
   logic         frame_err;
`ifdef TC_OVF_FLAG_EN
   logic         o_ovf;
`endif

   int checks = 0;
   int errors = 0;
   int ferr_cnt = 0;
   int vld_cyc = 0;

   tc_serial_decode #(.WIDTH(W)) dut (
      .t_clk    (t_clk),
      .r        (r),
      .i        (i),
      .i_vld    (i_vld),
      .sof      (sof),
      .i_rdy    (i_rdy),
      .o_word   (o_word),
      .o_raw    (o_raw),
      .o_vld    (o_vld),
      .o_rdy    (o_rdy),
      .frame_err(frame_err)
`ifdef TC_OVF_FLAG_EN
      ,
      .o_ovf    (o_ovf)
`endif
   );

   always #5 t_clk = ~t_clk;

   always @(negedge t_clk) begin
      if (frame_err) ferr_cnt++;
      if (o_vld) vld_cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] negate(input logic [W-1:0] x);
      return W'(0) - x;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge t_clk);
         #1;
      end
   endtask

   task automatic send(input logic b, input logic s);
      int n = 0;
      @(negedge t_clk);
      i_vld = 1'b1;
      i     = b;
      sof   = s;
      while (!i_rdy && n < 20) begin
         @(negedge t_clk);
         n++;
      end
      if (!i_rdy) chk("rdy_timeout", 32'(i_rdy), 32'd1);
      @(posedge t_clk);
      #1;
      i_vld = 1'b0;
      sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] raw, input int maxgap);
      for (int k = 0; k < W; k++) begin
         if (k > 0 && maxgap > 0) idle($urandom_range(maxgap, 0));
         send(raw[k], k == 0);
      end
   endtask

   task automatic do_reset();
      @(negedge t_clk);
      r = 1'b0;
      @(posedge t_clk);
      #1;
      chk("rst_vld", 32'(o_vld), 32'd0);
      chk("rst_word", 32'(o_word), 32'd0);
      chk("rst_raw", 32'(o_raw), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
`ifdef TC_OVF_FLAG_EN
      chk("rst_ovf", 32'(o_ovf), 32'd0);
`endif
      @(negedge t_clk);
      r = 1'b1;
      @(posedge t_clk);
      #1;
      chk("rst_rdy", 32'(i_rdy), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int fb;
      int vb;
      logic [W-1:0] raw;
      int gap, hold, pre, part;

      do_reset();

      // basic frame 0x06
      fb = ferr_cnt;
      vb = vld_cyc;
      o_rdy = 1'b1;
      send_frame(8'h06, 0);
      chk("basic_lat", 32'(o_vld), 32'd1);
      chk("basic_raw", 32'(o_raw), 32'h06);
      chk("basic_word", 32'(o_word), 32'hFA);
      idle(3);
      chk("basic_vld_cycles", 32'(vld_cyc - vb), 32'd1);
      chk("basic_ferr", 32'(ferr_cnt - fb), 32'd0);

      // back-pressure with frame 0x01
      o_rdy = 1'b0;
      send_frame(8'h01, 0);
      chk("bp_lat", 32'(o_vld), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge t_clk);
         chk("bp_vld", 32'(o_vld), 32'd1);
         chk("bp_word", 32'(o_word), 32'hFF);
         chk("bp_rdy", 32'(i_rdy), 32'd0);
      end
      o_rdy = 1'b1;
      @(posedge t_clk);
      #1;
      chk("bp_release_vld", 32'(o_vld), 32'd0);
      chk("bp_release_rdy", 32'(i_rdy), 32'd1);
`ifdef TC_OVF_FLAG_EN
      chk("bp_ovf_clear", 32'(o_ovf), 32'd0);
`endif

      // restart on 4th bit, then frame 0x80
      fb = ferr_cnt;
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send_frame(8'h80, 0);
      chk("rs_raw", 32'(o_raw), 32'h80);
      chk("rs_word", 32'(o_word), 32'h80);
`ifdef TC_OVF_FLAG_EN
      chk("rs_ovf", 32'(o_ovf), 32'd1);
`endif
      idle(2);
      chk("rs_ferr_once", 32'(ferr_cnt - fb), 32'd1);
`ifdef TC_OVF_FLAG_EN
      chk("rs_ovf_clear", 32'(o_ovf), 32'd0);
`endif

      // reset mid-frame after 5 one-bits
      fb = ferr_cnt;
      send(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) send(1'b1, 1'b0);
      do_reset();
      send_frame(8'h00, 0);
      chk("mr_raw", 32'(o_raw), 32'h00);
      chk("mr_word", 32'(o_word), 32'h00);
      idle(2);
      chk("mr_ferr", 32'(ferr_cnt - fb), 32'd0);

      // stray bits in IDLE and gaps inside the frame
      fb = ferr_cnt;
      for (int k = 0; k < 3; k++) send(1'b1, 1'b0);
      send_frame(8'hFF, 3);
      chk("gap_raw", 32'(o_raw), 32'hFF);
      chk("gap_word", 32'(o_word), 32'h01);
      idle(2);
      chk("gap_ferr", 32'(ferr_cnt - fb), 32'd0);

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         raw  = W'($urandom);
         gap  = $urandom_range(2, 0);
         hold = $urandom_range(3, 0);
         pre  = $urandom_range(3, 0);
         part = ($urandom_range(3, 0) == 0) ? $urandom_range(W - 1, 1) : 0;
         fb   = ferr_cnt;
         for (int k = 0; k < pre; k++) send(1'($urandom_range(1, 0)), 1'b0);
         for (int k = 0; k < part; k++) send(1'($urandom_range(1, 0)), k == 0);
         if (hold > 0) o_rdy = 1'b0;
         send_frame(raw, gap);
         chk("rnd_lat", 32'(o_vld), 32'd1);
         chk("rnd_raw", 32'(o_raw), 32'(raw));
         chk("rnd_word", 32'(o_word), 32'(negate(raw)));
         chk("rnd_ferr", 32'(ferr_cnt - fb), (part > 0) ? 32'd1 : 32'd0);
`ifdef TC_OVF_FLAG_EN
         chk("rnd_ovf", 32'(o_ovf), (raw == 8'h80) ? 32'd1 : 32'd0);
`endif
         for (int c = 0; c < hold; c++) begin
            idle(1);
            chk("rnd_hold_word", 32'(o_word), 32'(negate(raw)));
            chk("rnd_hold_rdy", 32'(i_rdy), 32'd0);
         end
         o_rdy = 1'b1;
         idle(1);
         chk("rnd_release", 32'(o_vld), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tc_serial_decode.md
TC_SERIAL_DECODE -- requirements
Module: tc_serial_decode

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the frame length in bits; legal range 2..32.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- t_clk  in  1  clock; all state changes on its rising edge.
- r  in  1  reset; synchronous, active-low.
- i  in  1  serial data bit of a two's-complemented stream, LSB first.
- i_vld  in  1  i is valid this cycle.
- sof  in  1  qualifies i as bit 0 of a frame; meaningful only when i_vld=1.
- i_rdy  out  1  block can accept a bit this cycle.
- o_word  out  WIDTH  recovered word, equal to the two's complement of o_raw.
- o_raw  out  WIDTH  received word as it arrived on the line.
- o_vld  out  1  o_word and o_raw are valid.
- o_rdy  in  1  downstream accepts the word.
- frame_err  out  1  one-cycle pulse; the current frame was aborted.

Function
REQ-003 A bit SHALL be accepted when i_vld=1 and i_rdy=1.
REQ-004 i_rdy SHALL be 1 in states IDLE and SHIFT, and 0 in state HOLD.
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and HOLD.
REQ-006 In IDLE, an accepted bit with sof=1 SHALL be taken as bit 0 and SHALL move the FSM to SHIFT.
REQ-007 In IDLE, an accepted bit with sof=0 SHALL be discarded, with no error.
REQ-008 Each accepted frame bit SHALL be stored at index = bit count; the bit count runs 0..WIDTH-1.
REQ-009 The serial inverse transform SHALL work per bit as follows:
- out = seen_one ? ~i : i
- then seen_one |= i
- seen_one is cleared at every accepted sof bit, before that bit is applied.
REQ-010 The transformed bit SHALL build o_word; the untransformed bit SHALL build o_raw.
REQ-011 When bit WIDTH-1 is accepted, the outputs SHALL be loaded, o_vld SHALL be 1 on the next cycle, and the FSM SHALL enter HOLD. Latency is one cycle from the last accepted bit.
REQ-012 In SHIFT, an accepted bit with sof=1 SHALL:
- pulse frame_err for one cycle;
- discard the partial frame;
- restart with that bit as bit 0, staying in SHIFT.
REQ-013 In SHIFT, cycles with i_vld=0 SHALL hold all state; there is no timeout.
REQ-014 In HOLD, o_vld, o_word and o_raw SHALL stay stable until o_vld=1 and o_rdy=1; the FSM then goes to IDLE on the next cycle.
REQ-015 i_vld asserted during HOLD SHALL be ignored; the sender must hold the bit until i_rdy=1.
REQ-016 A raw word of all zeros SHALL give o_word = 0.
REQ-017 For WIDTH=2 the FSM SHALL reach HOLD after the second accepted bit.

Reset
REQ-018 When r=0 at a rising edge of t_clk, the block SHALL set:
- FSM = IDLE, bit count = 0, seen_one = 0
- o_vld = 0, frame_err = 0
- o_word = 0, o_raw = 0
- o_ovf = 0 when present.
REQ-019 Reset SHALL take priority over every other event, including a reset in the middle of a frame or during HOLD; the partial frame is dropped and no frame_err pulse is issued.
REQ-020 i_rdy SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-021 With macro TC_OVF_FLAG_EN defined, the block SHALL have an extra output port o_ovf (out, 1 bit).
REQ-022 With TC_OVF_FLAG_EN defined:
- o_ovf is valid together with o_vld;
- o_ovf = 1 only when o_raw equals 1 followed by WIDTH-1 zeros, whose negation cannot be represented (o_word then equals o_raw);
- o_ovf is cleared on leaving HOLD.
REQ-023 With TC_OVF_FLAG_EN undefined, the o_ovf port and its logic SHALL be absent, and all other behaviour SHALL be the same.

Verification
REQ-024 The bench SHALL cover these scenarios with WIDTH=8:
- Basic frame: bits 0,1,1,0,0,0,0,0 with sof on the first bit, o_rdy=1 -> o_raw=0x06, o_word=0xFA, o_vld high for one cycle, one cycle after the last bit.
- Back-pressure: frame 0x01 with o_rdy=0 for 5 cycles -> o_word=0xFF held stable, i_rdy=0 throughout HOLD, IDLE one cycle after o_rdy=1.
- Restart: sof on the 4th bit of a frame, then 8 bits giving raw 0x80 -> frame_err pulses once; o_raw=0x80, o_word=0x80; o_ovf=1 when TC_OVF_FLAG_EN is defined.
- Reset mid-frame: r=0 after 5 bits, then a full frame giving raw 0x00 -> o_word=0x00, no frame_err, seen_one cleared.
- Gaps and stray bits: i_vld low between bits, and non-sof bits while IDLE -> those bits are ignored; a frame giving raw 0xFF returns o_word=0x01.
